// File: rtl/a_fsm_pkg.sv
// -----------------------------------------------------------------------------
// a_fsm_pkg
// Shared definitions for the input-A conditioning logic and the control FSM
// that consumes A.
//   STATE_W        : width of the debounce state register
//   DEF_STABLE_CNT : default number of consecutive equal samples needed
//   state_t        : debounce states (LO, LO_CHK, HI, HI_CHK)
// -----------------------------------------------------------------------------
package a_fsm_pkg;

   localparam int STATE_W        = 2;
   localparam int DEF_STABLE_CNT = 4;

   // Bit 1 of the encoding is the debounced level; bit 0 marks "qualifying".
   typedef enum logic [STATE_W-1:0] {
      LO     = 2'b00,
      LO_CHK = 2'b01,
      HI     = 2'b10,
      HI_CHK = 2'b11
   } state_t;

endpackage

// File: rtl/a_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// a_input_conditioner_if
// Bundles the conditioner's data signals. There is no valid/ready handshake:
// raw_a is a free-running level, A is a level, and a_rise/a_fall are
// single-cycle strobes that the consumer samples on every Clock edge.
//   raw_a      : raw asynchronous input
//   A          : debounced level
//   a_rise     : one-cycle strobe when A goes 0->1
//   a_fall     : one-cycle strobe when A goes 1->0
//   busy       : a candidate level change is being qualified
//   glitch_cnt : saturating count of rejected candidate transitions
//   state_dbg  : current debounce state, for observation only
// Modports: slave = the conditioner, master = the consumer/driver side.
// -----------------------------------------------------------------------------
interface a_input_conditioner_if #(
   parameter int GLITCH_W = 8
);
   import a_fsm_pkg::*;

   logic                raw_a;
   logic                A;
   logic                a_rise;
   logic                a_fall;
   logic                busy;
   logic [GLITCH_W-1:0] glitch_cnt;
   state_t              state_dbg;

   modport slave  (input  raw_a,
                   output A, a_rise, a_fall, busy, glitch_cnt, state_dbg);

   modport master (output raw_a,
                   input  A, a_rise, a_fall, busy, glitch_cnt, state_dbg);

endinterface

// File: rtl/bit_sync2.sv
// -----------------------------------------------------------------------------
// bit_sync2
// Two-flop synchroniser for a single asynchronous bit.
//   Clock : destination clock, rising edge
//   Reset : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (two Clock edges of latency)
// -----------------------------------------------------------------------------
module bit_sync2 (
   input  logic Clock,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic sync1;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 1'b0;
         q     <= 1'b0;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/a_input_conditioner.sv
// -----------------------------------------------------------------------------
// a_input_conditioner
// Synchronises and debounces the raw input A for the control FSM.
//   Clock : system clock, rising edge
//   Reset : asynchronous active-low reset
//   io    : a_input_conditioner_if.slave (raw_a in; A, a_rise, a_fall, busy,
//           glitch_cnt, state_dbg out)
// A level change on the synchronised input must persist for STABLE_CNT
// consecutive samples before A follows it; an earlier return to the current
// level aborts the attempt and bumps the saturating glitch counter.
// All outputs are registered.
// -----------------------------------------------------------------------------
module a_input_conditioner
   import a_fsm_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int CNT_W      = 16,
   parameter int GLITCH_W   = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   a_input_conditioner_if.slave  io
);

   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CNT - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   logic                s;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;
   logic                a_q, a_d;
   logic                rise_q, rise_d;
   logic                fall_q, fall_d;
   logic                busy_q, busy_d;

   bit_sync2 u_sync (
      .Clock (Clock),
      .Reset (Reset),
      .d     (io.raw_a),
      .q     (s)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= LO;
         cnt_q    <= '0;
         glitch_q <= '0;
         a_q      <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         glitch_q <= glitch_d;
         a_q      <= a_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      glitch_d = glitch_q;
      a_d      = a_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;

      case (state_q)
         LO: begin
            a_d = 1'b0;
            if (s) begin
               state_d = LO_CHK;
               cnt_d   = CNT_W'(1);
            end
         end
         LO_CHK: begin
            if (!s) begin
               state_d = LO;
               cnt_d   = '0;
               if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + GLITCH_W'(1);
            end else if (cnt_q == CNT_LAST) begin
               state_d = HI;
               cnt_d   = '0;
               a_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HI: begin
            a_d = 1'b1;
            if (!s) begin
               state_d = HI_CHK;
               cnt_d   = CNT_W'(1);
            end
         end
         HI_CHK: begin
            if (s) begin
               state_d = HI;
               cnt_d   = '0;
               if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + GLITCH_W'(1);
            end else if (cnt_q == CNT_LAST) begin
               state_d = LO;
               cnt_d   = '0;
               a_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LO;
            cnt_d   = '0;
            a_d     = 1'b0;
         end
      endcase

      // busy is registered alongside the state it describes.
      busy_d = (state_d == LO_CHK) || (state_d == HI_CHK);
   end

   assign io.A          = a_q;
   assign io.a_rise     = rise_q;
   assign io.a_fall     = fall_q;
   assign io.busy       = busy_q;
   assign io.glitch_cnt = glitch_q;
   assign io.state_dbg  = state_q;

endmodule

// File: tb/tb_a_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_a_input_conditioner
// Directed bench for a_input_conditioner with STABLE_CNT=4. A second instance
// with GLITCH_W=2 exercises glitch counter saturation. Inputs are driven on
// the falling edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_a_input_conditioner;
   import a_fsm_pkg::*;

   localparam int SC = 4;

   logic Clock = 1'b0;
   logic Reset;
   int   tests_run    = 0;
   int   tests_failed = 0;

   a_input_conditioner_if #(.GLITCH_W(8)) bus ();
   a_input_conditioner_if #(.GLITCH_W(2)) bus_g ();

   a_input_conditioner #(.STABLE_CNT(SC), .CNT_W(16), .GLITCH_W(8)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .io    (bus)
   );

   a_input_conditioner #(.STABLE_CNT(SC), .CNT_W(16), .GLITCH_W(2)) dut_g (
      .Clock (Clock),
      .Reset (Reset),
      .io    (bus_g)
   );

   // ---------------- clock / reset ----------------
   always #5 Clock = ~Clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic do_reset();
      Reset       = 1'b0;
      bus.raw_a   = 1'b0;
      bus_g.raw_a = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge Clock); #1;
      tests_run++;
      if ({bus.A, bus.a_rise, bus.a_fall, bus.busy} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_outputs: A/rise/fall/busy=%b%b%b%b expected 0000",
                  bus.A, bus.a_rise, bus.a_fall, bus.busy);
      end
      tests_run++;
      if (bus.glitch_cnt !== 8'd0 || bus_g.glitch_cnt !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_glitch: got %0d/%0d expected 0/0", bus.glitch_cnt, bus_g.glitch_cnt);
      end
      tests_run++;
      if (bus.state_dbg !== LO) begin
         tests_failed++;
         $display("FAIL reset_state: got %b expected %b", bus.state_dbg, LO);
      end
      @(negedge Clock);
      Reset = 1'b1;
   endtask

   task automatic test_clean_rise();
      logic exp_a, exp_r, exp_b;
      do_reset();
      @(negedge Clock);
      bus.raw_a = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(posedge Clock); #1;
         exp_a = (j >= 6);
         exp_r = (j == 6);
         exp_b = (j >= 3 && j <= 5);
         tests_run++;
         if (bus.A !== exp_a || bus.a_rise !== exp_r || bus.a_fall !== 1'b0 || bus.busy !== exp_b) begin
            tests_failed++;
            $display("FAIL clean_rise cyc %0d: A/rise/fall/busy=%b%b%b%b expected %b%b0%b",
                     j, bus.A, bus.a_rise, bus.a_fall, bus.busy, exp_a, exp_r, exp_b);
         end
      end
      tests_run++;
      if (bus.glitch_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL clean_rise_glitch: got %0d expected 0", bus.glitch_cnt);
      end
   endtask

   // Runs straight after test_clean_rise, so A=1 and raw_a=1 on entry.
   task automatic test_clean_fall();
      logic exp_a, exp_f, exp_b;
      @(negedge Clock);
      bus.raw_a = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         @(posedge Clock); #1;
         exp_a = (j < 6);
         exp_f = (j == 6);
         exp_b = (j >= 3 && j <= 5);
         tests_run++;
         if (bus.A !== exp_a || bus.a_fall !== exp_f || bus.a_rise !== 1'b0 || bus.busy !== exp_b) begin
            tests_failed++;
            $display("FAIL clean_fall cyc %0d: A/rise/fall/busy=%b%b%b%b expected %b0%b%b",
                     j, bus.A, bus.a_rise, bus.a_fall, bus.busy, exp_a, exp_f, exp_b);
         end
      end
      tests_run++;
      if (bus.glitch_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL clean_fall_glitch: got %0d expected 0", bus.glitch_cnt);
      end
   endtask

   task automatic test_bounce();
      logic       exp_a, exp_r;
      logic [7:0] exp_g;
      do_reset();
      @(negedge Clock);
      bus.raw_a = 1'b1;                // sampled at edges k, k+1
      @(negedge Clock);
      @(negedge Clock);
      bus.raw_a = 1'b0;                // sampled at edge k+2
      @(negedge Clock);
      tests_run++;
      if (bus.A !== 1'b0 || bus.a_rise !== 1'b0) begin
         tests_failed++;
         $display("FAIL bounce_early: A/rise=%b%b expected 00", bus.A, bus.a_rise);
      end
      bus.raw_a = 1'b1;                // final rise, first sampled at edge k+3
      for (int j = 1; j <= 12; j++) begin
         @(posedge Clock); #1;
         exp_a = (j >= 6);
         exp_r = (j == 6);
         exp_g = (j >= 2) ? 8'd1 : 8'd0;
         tests_run++;
         if (bus.A !== exp_a || bus.a_rise !== exp_r || bus.glitch_cnt !== exp_g) begin
            tests_failed++;
            $display("FAIL bounce cyc %0d: A/rise=%b%b glitch=%0d expected %b%b glitch=%0d",
                     j, bus.A, bus.a_rise, bus.glitch_cnt, exp_a, exp_r, exp_g);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic exp_a, exp_r;
      do_reset();
      @(negedge Clock);
      bus.raw_a = 1'b1;
      repeat (10) @(negedge Clock);
      tests_run++;
      if (bus.A !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_pre: A=%b expected 1", bus.A);
      end
      bus.raw_a = 1'b0;                // single low sample at edge k
      @(negedge Clock);
      bus.raw_a = 1'b1;
      @(posedge Clock);
      @(posedge Clock); #1;            // after edge k+2: HI_CHK
      tests_run++;
      if (bus.state_dbg !== HI_CHK || bus.busy !== 1'b1 || bus.A !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_chk: state=%b busy=%b A=%b expected %b 1 1",
                  bus.state_dbg, bus.busy, bus.A, HI_CHK);
      end
      @(negedge Clock); #2;
      Reset = 1'b0;
      #1;
      tests_run++;
      if ({bus.A, bus.a_rise, bus.a_fall, bus.busy} !== 4'b0000 || bus.glitch_cnt !== 8'd0
          || bus.state_dbg !== LO) begin
         tests_failed++;
         $display("FAIL reset_mid_async: A/rise/fall/busy=%b%b%b%b glitch=%0d state=%b expected 0000 0 %b",
                  bus.A, bus.a_rise, bus.a_fall, bus.busy, bus.glitch_cnt, bus.state_dbg, LO);
      end
      repeat (3) @(negedge Clock);
      Reset = 1'b1;                    // raw_a still 1: next edge is the first sample
      for (int j = 1; j <= 10; j++) begin
         @(posedge Clock); #1;
         exp_a = (j >= 6);
         exp_r = (j == 6);
         tests_run++;
         if (bus.A !== exp_a || bus.a_rise !== exp_r || bus.a_fall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_rise cyc %0d: A/rise/fall=%b%b%b expected %b%b0",
                     j, bus.A, bus.a_rise, bus.a_fall, exp_a, exp_r);
         end
      end
   endtask

   task automatic test_glitch_sat();
      logic [1:0] exp_g;
      do_reset();
      for (int p = 1; p <= 5; p++) begin
         @(negedge Clock);
         bus_g.raw_a = 1'b1;
         @(negedge Clock);
         bus_g.raw_a = 1'b0;
         repeat (4) @(posedge Clock);
         #1;
         exp_g = (p < 3) ? 2'(p) : 2'd3;
         tests_run++;
         if (bus_g.glitch_cnt !== exp_g || bus_g.A !== 1'b0 || bus_g.a_rise !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_sat pulse %0d: glitch=%0d A=%b rise=%b expected glitch=%0d A=0 rise=0",
                     p, bus_g.glitch_cnt, bus_g.A, bus_g.a_rise, exp_g);
         end
      end
   endtask

   task automatic test_soak();
      logic       r, m1, m2, prev_a;
      logic [4:0] hist;
      int         hold;
      int         changes;
      do_reset();
      r = 1'b0; m1 = 1'b0; m2 = 1'b0; prev_a = 1'b0;
      hist = '0; hold = 0; changes = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge Clock);
         if (hold == 0) begin
            r    = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 10);
         end
         hold--;
         bus.raw_a = r;
         @(posedge Clock);
         m2   = m1;
         m1   = r;
         hist = {hist[3:0], m2};
         #1;
         if (bus.A !== prev_a) begin
            changes++;
            tests_run++;
            if (hist[4:1] !== {SC{bus.A}}) begin
               tests_failed++;
               $display("FAIL soak_stable cyc %0d: A=%b sync history=%b", c, bus.A, hist[4:1]);
            end
         end
         tests_run++;
         if (bus.a_rise !== (bus.A & ~prev_a) || bus.a_fall !== (~bus.A & prev_a)
             || (bus.a_rise & bus.a_fall)) begin
            tests_failed++;
            $display("FAIL soak_strobe cyc %0d: A=%b prevA=%b rise=%b fall=%b",
                     c, bus.A, prev_a, bus.a_rise, bus.a_fall);
         end
         prev_a = bus.A;
      end
      tests_run++;
      if (changes == 0) begin
         tests_failed++;
         $display("FAIL soak_activity: A changed %0d times expected >0", changes);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      Reset       = 1'b0;
      bus.raw_a   = 1'b0;
      bus_g.raw_a = 1'b0;
      test_reset();
      test_clean_rise();
      test_clean_fall();
      test_bounce();
      test_reset_mid();
      test_glitch_sat();
      test_soak();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
